tlb_op_unit: RTL and testbench
==============================

TLB_OP_UNIT -- requirements
Module: tlb_op_unit

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 16, meaning the number of TLB entries (power of two).
REQ-002 SHALL have parameter TLB_INDEX, default 4, meaning the index width, equal to log2(TLB_ENTRIES).
REQ-003 SHALL have port clk  in  1  system clock, rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have port op_valid  in  1  TLB operation request.
REQ-006 SHALL have port op_type  in  2  tu_op_t operation code: TLBP=0, TLBR=1, TLBWI=2, TLBWR=3.
REQ-007 SHALL have port op_ready  out  1  request accept strobe; a request is accepted when op_valid&op_ready.
REQ-008 SHALL have ports entryhi, entrylo0, entrylo1 and index  in  32 each  CP0 operand registers (cp0_entryhi_t, cp0_entrylo_t, cp0_index_t).
REQ-009 SHALL have port wired  in  TLB_INDEX  CP0 Wired value.
REQ-010 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port tu_op_resp  out  tu_op_resp_t  index/entryhi/entrylo0/entrylo1 result; valid only while resp_valid=1.
REQ-012 SHALL have port random  out  TLB_INDEX  current Random value for CP0 reads.

Function
REQ-013 The FSM SHALL have states IDLE, PROBE and RESP; op_ready=1 only in IDLE.
REQ-014 Operands and op_type SHALL be captured on the accept edge; later input changes SHALL be ignored.
REQ-015 TLBP SHALL go IDLE->PROBE->RESP->IDLE: match vector registered in PROBE; resp_valid 2 cycles after accept.
REQ-016 An entry SHALL match when vpn2 equals entryhi.vpn2 and (G=1 or asid equals entryhi.asid); on multiple matches the lowest index SHALL win.
REQ-017 TLBP response: hit -> index={P=0, zeros, idx}; miss -> P(bit31)=1, low bits 0; other response fields SHALL be 0.
REQ-018 TLBR SHALL go IDLE->RESP->IDLE with resp_valid 1 cycle after accept, returning the entry at index[TLB_INDEX-1:0].
REQ-019 TLBR response: entryhi holds vpn2/asid; both entrylo G bits hold the stored G; other response fields SHALL be 0.
REQ-020 TLBWI SHALL write the entry at index[TLB_INDEX-1:0] on the accept edge; TLBWR SHALL write the entry at the random value sampled in the accept cycle.
REQ-021 A write SHALL store vpn2, asid, G=entrylo0.G&entrylo1.G, and per page PFN, C, D and V; resp_valid (ack, fields 0) SHALL follow 1 cycle after accept.
REQ-022 A TLBP or TLBR issued immediately after a write SHALL observe the written entry.
REQ-023 random SHALL decrement every cycle; when it equals wired it SHALL load TLB_ENTRIES-1 next cycle.
REQ-024 A change of wired SHALL load TLB_ENTRIES-1 into random next cycle; if wired>=TLB_ENTRIES-1, random SHALL hold TLB_ENTRIES-1.

Reset
REQ-025 Asserting resetn low SHALL immediately set: FSM=IDLE, op_ready=1 after release, resp_valid=0, tu_op_resp=0, random=TLB_ENTRIES-1, and all entries zero (V=0, G=0).
REQ-026 Reset mid-operation SHALL drop the pending response; a write accepted on an earlier edge SHALL be lost along with the rest of the array.

Configuration
REQ-027 With TLBWR_EN defined, TLBWR SHALL use random and the Random counter SHALL be built.
REQ-028 Without TLBWR_EN, TLBWR SHALL behave exactly as TLBWI, and random SHALL be constant TLB_ENTRIES-1.

Structure
REQ-029 translation_pkg SHALL hold tlb_entry_t, tu_op_t, tu_op_resp_t, TLB_ENTRIES and TLB_INDEX.
REQ-030 The Random counter SHALL be sub-module tlb_random (inputs clk, resetn, wired; output random).

Verification
REQ-031 Write entry 3 via TLBWI (vpn2=0x12345, asid=0x05, G=0), then TLBP with same vpn2, asid=0x05 -> resp_valid at accept+2, index=0x00000003.
REQ-032 Same probe with asid=0x06 -> index=0x80000000; rewrite entry 3 with both G=1, then probe asid=0x06 -> index=0x00000003.
REQ-033 Write entries 2 and 7 with identical vpn2/asid, then TLBP -> index=2; TLBR index=7 -> resp at accept+1 with the written fields.
REQ-034 Set wired=4 -> random sequence 15,14,...,4,15; TLBWR issued when random=9 -> entry 9 written (without TLBWR_EN: entry index[3:0] written).
REQ-035 Hold op_valid during PROBE -> op_ready=0 with no second accept; assert resetn low in PROBE -> no resp_valid and TLBR of any entry returns 0.

Source files
------------

// File: rtl/translation_pkg.sv
// translation_pkg: TLB entry and CP0 register layouts, operation codes and sizing constants
// shared by the TLB operation unit and its Random counter.
package translation_pkg;
    localparam int TLB_ENTRIES = 16;
    localparam int TLB_INDEX   = 4;

    typedef enum logic [1:0] {TLBP = 2'd0, TLBR = 2'd1, TLBWI = 2'd2, TLBWR = 2'd3} tu_op_t;
    typedef enum logic [1:0] {IDLE = 2'd0, PROBE = 2'd1, RESP = 2'd2} tu_state_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [4:0]  rsvd;
        logic [7:0]  asid;
    } cp0_entryhi_t;

    typedef struct packed {
        logic [5:0]  rsvd;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        g;
    } cp0_entrylo_t;

    typedef struct packed {
        logic        p;
        logic [30:0] idx;
    } cp0_index_t;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    typedef struct packed {
        cp0_index_t   index;
        cp0_entryhi_t entryhi;
        cp0_entrylo_t entrylo0;
        cp0_entrylo_t entrylo1;
    } tu_op_resp_t;

    function automatic tlb_page_t lo_to_page(cp0_entrylo_t lo);
        return {lo.pfn, lo.c, lo.d, lo.v};
    endfunction

    function automatic cp0_entrylo_t page_to_lo(tlb_page_t p, logic g);
        return {6'b0, p, g};
    endfunction
endpackage

// File: rtl/tlb_random.sv
// tlb_random: CP0 Random counter, counts down from TLB_ENTRIES-1 to wired and wraps;
// any change of wired restarts the count at the top.
module tlb_random #(
    parameter int TLB_ENTRIES = 16,
    parameter int TLB_INDEX   = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [TLB_INDEX-1:0] wired,
    output logic [TLB_INDEX-1:0] random
);
    localparam logic [TLB_INDEX-1:0] TOP = TLB_INDEX'(TLB_ENTRIES - 1);

    logic [TLB_INDEX-1:0] wired_q;

    // random==wired also covers wired at the top value, which pins random there
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random  <= TOP;
            wired_q <= '0;
        end else begin
            wired_q <= wired;
            random  <= (wired != wired_q || random == wired) ? TOP : random - 1'b1;
        end
    end
endmodule

// File: rtl/tlb_op_unit.sv
// tlb_op_unit: executes TLBP/TLBR/TLBWI/TLBWR against a register-based TLB array.
// Define TLBWR_EN to build the Random counter and make TLBWR write at the random index.
module tlb_op_unit #(
    parameter int TLB_ENTRIES = translation_pkg::TLB_ENTRIES,
    parameter int TLB_INDEX   = translation_pkg::TLB_INDEX
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         op_valid,
    input  translation_pkg::tu_op_t      op_type,
    output logic                         op_ready,
    input  translation_pkg::cp0_entryhi_t entryhi,
    input  translation_pkg::cp0_entrylo_t entrylo0,
    input  translation_pkg::cp0_entrylo_t entrylo1,
    input  translation_pkg::cp0_index_t  index,
    input  logic [TLB_INDEX-1:0]         wired,
    output logic                         resp_valid,
    output translation_pkg::tu_op_resp_t tu_op_resp,
    output logic [TLB_INDEX-1:0]         random
);
    import translation_pkg::*;

    localparam logic [TLB_INDEX-1:0] TOP = TLB_INDEX'(TLB_ENTRIES - 1);

    tu_state_t              state, state_nx;
    tlb_entry_t             tlb [TLB_ENTRIES];
    tlb_entry_t             rd;
    tu_op_t                 op_q;
    logic [18:0]            vpn2_q;
    logic [7:0]             asid_q;
    logic [TLB_INDEX-1:0]   idx_q, wr_idx, hit_idx;
    logic [TLB_ENTRIES-1:0] match, match_q;
    logic                   accept, is_write, unused_bits;

    assign accept   = op_valid && op_ready;
    assign is_write = op_type == TLBWI || op_type == TLBWR;
    assign rd       = tlb[idx_q];

`ifdef TLBWR_EN
    tlb_random #(.TLB_ENTRIES(TLB_ENTRIES), .TLB_INDEX(TLB_INDEX)) u_random (
        .clk    (clk),
        .resetn (resetn),
        .wired  (wired),
        .random (random)
    );
    assign wr_idx      = op_type == TLBWR ? random : index.idx[TLB_INDEX-1:0];
    assign unused_bits = ^{entryhi.rsvd, entrylo0.rsvd, entrylo1.rsvd, index.p, index.idx[30:TLB_INDEX]};
`else
    assign random      = TOP;
    assign wr_idx      = index.idx[TLB_INDEX-1:0];
    assign unused_bits = ^{entryhi.rsvd, entrylo0.rsvd, entrylo1.rsvd, index.p, index.idx[30:TLB_INDEX], wired};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == PROBE ? RESP :
                   state == RESP  ? IDLE :
                   accept ? (op_type == TLBP ? PROBE : RESP) : IDLE;
    end

    always_comb begin
        op_ready   = state == IDLE;
        resp_valid = state == RESP;
        tu_op_resp = '0;
        if (state == RESP && op_q == TLBP) begin
            tu_op_resp.index.p   = ~|match_q;
            tu_op_resp.index.idx = |match_q ? 31'(hit_idx) : '0;
        end
        if (state == RESP && op_q == TLBR) begin
            tu_op_resp.entryhi  = {rd.vpn2, 5'b0, rd.asid};
            tu_op_resp.entrylo0 = page_to_lo(rd.p0, rd.g);
            tu_op_resp.entrylo1 = page_to_lo(rd.p1, rd.g);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= TLBP;
            vpn2_q <= '0;
            asid_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            op_q   <= op_type;
            vpn2_q <= entryhi.vpn2;
            asid_q <= entryhi.asid;
            idx_q  <= index.idx[TLB_INDEX-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tlb <= '{default: '0};
        else if (accept && is_write)
            tlb[wr_idx] <= '{vpn2: entryhi.vpn2, asid: entryhi.asid, g: entrylo0.g & entrylo1.g,
                             p0: lo_to_page(entrylo0), p1: lo_to_page(entrylo1)};
    end

    for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_match
        assign match[i] = tlb[i].vpn2 == vpn2_q && (tlb[i].g || tlb[i].asid == asid_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) match_q <= '0;
        else if (state == PROBE) match_q <= match;
    end

    // scanning downwards leaves the lowest matching index
    always_comb begin
        hit_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--)
            if (match_q[i]) hit_idx = TLB_INDEX'(i);
    end
endmodule

// File: tb/tb_tlb_op_unit.sv
// tb_tlb_op_unit: directed and randomized checks of tlb_op_unit against an array-level model.
module tb_tlb_op_unit;
    import translation_pkg::*;

    logic        clk = 0, resetn = 0, op_valid = 0;
    tu_op_t      op_type = TLBP;
    logic        op_ready, resp_valid;
    logic [31:0] entryhi = 0, entrylo0 = 0, entrylo1 = 0, index = 0;
    logic [3:0]  wired = 0, random;
    tu_op_resp_t tu_op_resp;
    int          checks = 0, failures = 0;

    tlb_op_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .op_valid   (op_valid),
        .op_type    (op_type),
        .op_ready   (op_ready),
        .entryhi    (entryhi),
        .entrylo0   (entrylo0),
        .entrylo1   (entrylo1),
        .index      (index),
        .wired      (wired),
        .resp_valid (resp_valid),
        .tu_op_resp (tu_op_resp),
        .random     (random)
    );

    always #5 clk = ~clk;

    logic [18:0] m_vpn2 [16];
    logic [7:0]  m_asid [16];
    logic        m_g    [16];
    logic [24:0] m_pg0  [16];
    logic [24:0] m_pg1  [16];
    logic [18:0] pool   [4] = '{19'h12345, 19'h0abcd, 19'h00001, 19'h7ffff};

    function automatic void m_clear();
        for (int i = 0; i < 16; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_pg0[i] = '0; m_pg1[i] = '0;
        end
    endfunction

    function automatic logic [31:0] m_probe(logic [31:0] eh);
        for (int i = 0; i < 16; i++)
            if (m_vpn2[i] == eh[31:13] && (m_g[i] || m_asid[i] == eh[7:0])) return 32'(i);
        return 32'h8000_0000;
    endfunction

`ifdef TLBWR_EN
    // Random after k edges since reset or the last wired change: 15 - k mod (16 - wired)
    int         since;
    logic [3:0] wired_seen;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            since      <= 0;
            wired_seen <= 0;
        end else begin
            wired_seen <= wired;
            since      <= (wired != wired_seen) ? 0 : since + 1;
        end
    end
    function automatic logic [3:0] exp_random();
        return wired_seen == 4'd15 ? 4'd15 : 4'(15 - since % (16 - int'(wired_seen)));
    endfunction
`else
    function automatic logic [3:0] exp_random();
        return 4'd15;
    endfunction
`endif

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        op_type  = tu_op_t'($urandom_range(0, 3));
        entryhi  = $urandom;
        entrylo0 = $urandom;
        entrylo1 = $urandom;
        index    = $urandom;
    endtask

    task automatic run_op(input tu_op_t t, input logic [31:0] eh, lo0, lo1, ix, output tu_op_resp_t r);
        tu_op_resp_t exp;
        logic [3:0]  i;
        int          lat;
        exp = '0;
        i = ix[3:0];
        if (t == TLBP) exp.index = m_probe(eh);
        else if (t == TLBR) begin
            exp.entryhi  = {m_vpn2[i], 5'b0, m_asid[i]};
            exp.entrylo0 = {6'b0, m_pg0[i], m_g[i]};
            exp.entrylo1 = {6'b0, m_pg1[i], m_g[i]};
        end else begin
`ifdef TLBWR_EN
            if (t == TLBWR) i = exp_random();
`endif
            m_vpn2[i] = eh[31:13];
            m_asid[i] = eh[7:0];
            m_g[i]    = lo0[0] & lo1[0];
            m_pg0[i]  = lo0[25:1];
            m_pg1[i]  = lo1[25:1];
        end
        check("ready_before", 128'(op_ready), 128'(1));
        op_type = t; entryhi = eh; entrylo0 = lo0; entrylo1 = lo1; index = ix; op_valid = 1;
        @(negedge clk);
        scramble();
        #1;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            check("busy_ready", 128'(op_ready), 128'(0));
            @(negedge clk);
            scramble();
            #1;
            lat++;
        end
        check("latency", 128'(lat), 128'(t == TLBP ? 2 : 1));
        check("resp", tu_op_resp, exp);
        r = tu_op_resp;
        op_valid = 0;
        @(negedge clk);
        check("after_valid", 128'(resp_valid), 128'(0));
        check("after_ready", 128'(op_ready), 128'(1));
        check("after_resp", tu_op_resp, 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tu_op_resp_t r;
        logic [31:0] eh, eh5, eh6, eh2;
        m_clear();
        repeat (3) @(negedge clk);
        check("rst_valid", 128'(resp_valid), 128'(0));
        check("rst_resp", tu_op_resp, 128'(0));
        check("rst_random", 128'(random), 128'(15));
        resetn = 1;
        @(negedge clk);
        check("rel_ready", 128'(op_ready), 128'(1));

        eh5 = {19'h12345, 5'b0, 8'h05};
        eh6 = {19'h12345, 5'b0, 8'h06};
        run_op(TLBWI, eh5, 32'hfc12_3456, 32'h0076_5433, 32'd3, r);
        run_op(TLBP, eh5, 0, 0, 0, r);
        check("probe_hit", 128'(r.index), 128'(32'h0000_0003));
        run_op(TLBP, eh6, 0, 0, 0, r);
        check("probe_miss", 128'(r.index), 128'(32'h8000_0000));
        run_op(TLBWI, eh5, 32'h0012_3457, 32'h0076_5433, 32'd3, r);
        run_op(TLBP, eh6, 0, 0, 0, r);
        check("probe_global", 128'(r.index), 128'(32'h0000_0003));

        eh2 = {19'h0abcd, 5'b0, 8'h22};
        run_op(TLBWI, eh2, 32'h0000_1a5e, 32'h0000_2a6e, 32'd7, r);
        run_op(TLBWI, eh2, 32'h0003_0006, 32'h0004_0002, 32'd2, r);
        run_op(TLBP, eh2, 0, 0, 0, r);
        check("probe_lowest", 128'(r.index), 128'(32'h0000_0002));
        run_op(TLBR, 0, 0, 0, 32'd7, r);
        check("read_hi", 128'(r.entryhi), 128'(eh2));
        check("read_lo0", 128'(r.entrylo0), 128'(32'h0000_1a5e));

        wired = 4;
`ifdef TLBWR_EN
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("random_seq", 128'(random), 128'(15 - k % 12));
        end
        for (int n = 0; n < 20 && exp_random() != 4'd9; n++) @(negedge clk);
        check("random_9", 128'(random), 128'(9));
`else
        repeat (5) @(negedge clk);
        check("random_const", 128'(random), 128'(15));
`endif
        run_op(TLBWR, {19'h55555, 5'b0, 8'h3c}, 32'h0111_1117, 32'h0222_2223, 32'd12, r);
        run_op(TLBR, 0, 0, 0, 32'd9, r);
        run_op(TLBR, 0, 0, 0, 32'd12, r);

        for (int n = 0; n < 60; n++) begin
            eh = {pool[$urandom_range(0, 3)], 5'($urandom), 8'($urandom_range(0, 3))};
            run_op(tu_op_t'($urandom_range(0, 3)), eh, $urandom, $urandom, $urandom, r);
            check("random_track", 128'(random), 128'(exp_random()));
        end

        // a write whose response is cut off by reset must not survive
        op_type = TLBWI; entryhi = eh5; entrylo0 = 32'h0000_0003; entrylo1 = 32'h0000_0003; index = 32'd6;
        op_valid = 1;
        @(negedge clk);
        op_valid = 0;
        check("wr_resp", 128'(resp_valid), 128'(1));
        resetn = 0;
        #1;
        check("rst_wr_valid", 128'(resp_valid), 128'(0));
        check("rst_wr_resp", tu_op_resp, 128'(0));
        m_clear();
        @(negedge clk);
        resetn = 1;
        @(negedge clk);

        op_type = TLBP; entryhi = eh5; op_valid = 1;
        @(negedge clk);
        check("probe_ready", 128'(op_ready), 128'(0));
        resetn = 0;
        #1;
        op_valid = 0;
        check("rst_probe_valid", 128'(resp_valid), 128'(0));
        check("rst_probe_random", 128'(random), 128'(15));
        @(negedge clk);
        resetn = 1;
        repeat (2) begin
            @(negedge clk);
            check("no_late_resp", 128'(resp_valid), 128'(0));
        end
        for (int k = 0; k < 16; k += 3) begin
            run_op(TLBR, 0, 0, 0, 32'(k), r);
            check("cleared", r, 128'(0));
        end
        run_op(TLBR, 0, 0, 0, 32'd6, r);
        check("lost_write", r, 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
